unsigned_dotprod_accum_26_17_48_bit: RTL and testbench

UNSIGNED_DOTPROD_ACCUM_26_17_48_BIT -- requirements
Module: unsigned_dotprod_accum_26_17_48_bit

---
 rtl/unsigned_dotprod_accum_26_17_48_bit_pkg.sv | 16 +
 rtl/unsigned_dotprod_accum_26_17_48_bit_mul.sv | 43 ++++
 rtl/unsigned_dotprod_accum_26_17_48_bit.sv | 108 ++++++++++
 tb/tb_unsigned_dotprod_accum_26_17_48_bit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/unsigned_dotprod_accum_26_17_48_bit_pkg.sv
// Shared constants for the DSP48E2-style unsigned dot-product accumulator.
// Holds the operand, accumulator and length-counter widths and a saturating increment.
package unsigned_dotprod_accum_26_17_48_bit_pkg;

    localparam int DP_A_W   = 26;
    localparam int DP_B_W   = 17;
    localparam int DP_P_W   = 48;
    localparam int DP_LEN_W = 16;

    localparam logic [DP_LEN_W-1:0] DP_LEN_MAX = '1;

    function automatic logic [DP_LEN_W-1:0] len_sat_inc(input logic [DP_LEN_W-1:0] v);
        return (v == DP_LEN_MAX) ? v : v + {{(DP_LEN_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/unsigned_dotprod_accum_26_17_48_bit_mul.sv
// Single registered a*b stage with clock enable and valid/last sideband,
// shaped to land in the DSP48E2 multiplier with its M register.
module unsigned_mul_1_stage_26_17_bit
    import unsigned_dotprod_accum_26_17_48_bit_pkg::*;
#(
    parameter int A_W = DP_A_W,
    parameter int B_W = DP_B_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [A_W-1:0]       in_a,
    input  logic [B_W-1:0]       in_b,
    output logic                 m_valid,
    output logic                 m_last,
    output logic [A_W+B_W-1:0]   m_prod
);

    localparam int M_W = A_W + B_W;

    logic           r_valid;
    logic           r_last;
    logic [M_W-1:0] r_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_prod  <= '0;
        end else if (ce) begin
            r_valid <= in_valid;
            r_last  <= in_last;
            r_prod  <= M_W'(in_a) * M_W'(in_b);
        end
    end

    assign m_valid = r_valid;
    assign m_last  = r_last;
    assign m_prod  = r_prod;

endmodule

// File: rtl/unsigned_dotprod_accum_26_17_48_bit.sv
// Streaming unsigned dot product: one a*b term per beat, summed per vector
// (delimited by in_last) into a 48-bit result with carry flag and term count.
module unsigned_dotprod_accum_26_17_48_bit
    import unsigned_dotprod_accum_26_17_48_bit_pkg::*;
#(
    parameter int A_W = DP_A_W,
    parameter int B_W = DP_B_W,
    parameter int P_W = DP_P_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       in_a,
    input  logic [B_W-1:0]       in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [P_W-1:0]       out_sum,
    output logic                 out_ovf,
    output logic [DP_LEN_W-1:0]  out_len
);

    localparam int M_W = A_W + B_W;

    logic                w_en;
    logic                w_m_valid;
    logic                w_m_last;
    logic [M_W-1:0]      w_m_prod;
    logic [P_W-1:0]      w_base;
    logic [P_W:0]        w_sum;
    logic                w_ovf;
    logic [DP_LEN_W-1:0] w_len;

    logic                r_first;
    logic [P_W-1:0]      r_acc;
    logic                r_ovf_acc;
    logic [DP_LEN_W-1:0] r_len_acc;
    logic                r_out_valid;
    logic [P_W-1:0]      r_out_sum;
    logic                r_out_ovf;
    logic [DP_LEN_W-1:0] r_out_len;

    // The whole pipe advances only when the result slot is free or being drained.
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    unsigned_mul_1_stage_26_17_bit #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .ce       (w_en),
        .in_valid (in_valid && w_en),
        .in_last  (in_last),
        .in_a     (in_a),
        .in_b     (in_b),
        .m_valid  (w_m_valid),
        .m_last   (w_m_last),
        .m_prod   (w_m_prod)
    );

    // Opmode-style select: the first term of a vector adds to zero, not to P.
    always_comb begin
        w_base = r_first ? '0 : r_acc;
        w_sum  = {1'b0, w_base} + (P_W+1)'(w_m_prod);
        w_ovf  = r_ovf_acc | w_sum[P_W];
        w_len  = len_sat_inc(r_len_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_first     <= 1'b1;
            r_acc       <= '0;
            r_ovf_acc   <= 1'b0;
            r_len_acc   <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_len   <= '0;
        end else if (w_en) begin
            r_out_valid <= w_m_valid && w_m_last;
            if (w_m_valid) begin
                if (w_m_last) begin
                    r_out_sum <= w_sum[P_W-1:0];
                    r_out_ovf <= w_ovf;
                    r_out_len <= w_len;
                    r_first   <= 1'b1;
                    r_acc     <= '0;
                    r_ovf_acc <= 1'b0;
                    r_len_acc <= '0;
                end else begin
                    r_acc     <= w_sum[P_W-1:0];
                    r_first   <= 1'b0;
                    r_ovf_acc <= w_ovf;
                    r_len_acc <= w_len;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;
    assign out_len   = r_out_len;

endmodule

// File: tb/tb_unsigned_dotprod_accum_26_17_48_bit.sv
// Scoreboard bench: stimulus pushes expected per-vector results, a negedge
// monitor pops and compares on every out_valid && out_ready handshake.
module tb_unsigned_dotprod_accum_26_17_48_bit;
    import unsigned_dotprod_accum_26_17_48_bit_pkg::*;

    localparam logic [47:0] MAXP = (48'd1 << 43) - (48'd1 << 26) - (48'd1 << 17) + 48'd1;
    localparam logic [47:0] SUM40 = 48'h3FFF5FB00028;
    localparam logic [25:0] MAXA = '1;
    localparam logic [16:0] MAXB = '1;

    typedef struct packed {
        logic [47:0] sum;
        logic        ovf;
        logic [15:0] len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] in_a;
    logic [16:0] in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_sum;
    logic        out_ovf;
    logic [15:0] out_len;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   rdy_mode = 0;

    logic        hold_v = 1'b0;
    logic [47:0] hold_sum;
    logic        hold_ovf;
    logic [15:0] hold_len;

    always #5 clk = ~clk;

    unsigned_dotprod_accum_26_17_48_bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_len   (out_len)
    );

    function automatic exp_t mk_exp(input logic [47:0] s, input logic o, input logic [15:0] l);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        e.len = l;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // out_ready driver: 0 = low, 1 = high, 2 = random, 3 = left to the main sequence
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            2: out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && out_valid) begin
                check("hold_sum", 64'(out_sum), 64'(hold_sum));
                check("hold_ovf", 64'(out_ovf), 64'(hold_ovf));
                check("hold_len", 64'(out_len), 64'(hold_len));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got sum 0x%0h with no result outstanding", out_sum);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("res_sum", 64'(out_sum), 64'(e.sum));
                    check("res_ovf", 64'(out_ovf), 64'(e.ovf));
                    check("res_len", 64'(out_len), 64'(e.len));
                    $display("result sum=0x%0h ovf=%0d len=%0d (expected 0x%0h %0d %0d)",
                             out_sum, out_ovf, out_len, e.sum, e.ovf, e.len);
                end
                hold_v = 1'b0;
            end else if (out_valid) begin
                hold_v   = 1'b1;
                hold_sum = out_sum;
                hold_ovf = out_ovf;
                hold_len = out_len;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    // Presents one beat from posedge+1 and returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [25:0] a, input logic [16:0] b, input logic last);
        int   t;
        logic ok;
        t  = 0;
        ok = 1'b0;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 500);
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: beat a=0x%0h b=0x%0h not accepted, required acceptance within 500 cycles", a, b);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        check("rst_out_len", 64'(out_len), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rdy_mode = 1;
        idle(1);

        // 3*5 + 7*11 + 2*13 = 118, with result-latency check
        exp_q.push_back(mk_exp(48'd118, 1'b0, 16'd3));
        send_beat(26'd3, 17'd5, 1'b0);
        send_beat(26'd7, 17'd11, 1'b0);
        send_beat(26'd2, 17'd13, 1'b1);
        check("lat_accept_edge", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_next_edge", 64'(out_valid), 64'd1);
        idle(3);

        exp_q.push_back(mk_exp(MAXP, 1'b0, 16'd1));
        send_beat(MAXA, MAXB, 1'b1);
        idle(3);

        exp_q.push_back(mk_exp(SUM40, 1'b1, 16'd40));
        for (int i = 0; i < 40; i++) send_beat(MAXA, MAXB, (i == 39));
        idle(4);

        // Two single-beat vectors into a stalled output
        rdy_mode = 3;
        out_ready = 1'b0;
        exp_q.push_back(mk_exp(48'd1, 1'b0, 16'd1));
        exp_q.push_back(mk_exp(48'd4, 1'b0, 16'd1));
        send_beat(26'd1, 17'd1, 1'b1);
        send_beat(26'd2, 17'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_first_sum", 64'(out_sum), 64'd1);
            idle(1);
        end
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        check("reload_out_valid", 64'(out_valid), 64'd1);
        check("reload_out_sum", 64'(out_sum), 64'd4);
        idle(2);
        rdy_mode = 1;
        idle(3);
        check("stall_drained", 64'(exp_q.size()), 64'd0);

        // Reset one cycle after a non-last beat discards the partial vector
        send_beat(26'd9, 17'd9, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.push_back(mk_exp(48'd16, 1'b0, 16'd1));
        send_beat(26'd4, 17'd4, 1'b1);
        idle(3);

        // Random operands, bubbles and back-pressure against a 64-bit reference sum
        rdy_mode = 2;
        for (int v = 0; v < 20; v++) begin
            int          n;
            logic [25:0] av[8];
            logic [16:0] bv[8];
            logic [63:0] acc;
            logic        ovf;
            n   = $urandom_range(1, 8);
            acc = 64'd0;
            ovf = 1'b0;
            for (int k = 0; k < n; k++) begin
                av[k] = ($urandom_range(0, 3) == 0) ? MAXA : 26'($urandom);
                bv[k] = ($urandom_range(0, 3) == 0) ? MAXB : 17'($urandom);
                acc = acc + 64'(av[k]) * 64'(bv[k]);
                if (acc[48]) ovf = 1'b1;
                acc = acc & 64'hFFFF_FFFF_FFFF;
            end
            exp_q.push_back(mk_exp(acc[47:0], ovf, 16'(n)));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
                send_beat(av[k], bv[k], (k == n - 1));
            end
        end

        rdy_mode = 1;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) idle(1);
        check("final_drained", 64'(exp_q.size()), 64'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
